cdc_sync_handshake: RTL and testbench
=====================================

// Module: cdc_sync_handshake
// PURPOSE
// - Single-clock, 4-phase req/ack handshake buffer between a producer and a consumer port.
// - req/ack inputs are treated as asynchronous and pass through SYNC_STAGES-flop synchronizers.
// - Words are captured into a BUFFER_DEPTH-entry FIFO and re-issued on the output handshake.
// - Decouples a slow or irregular producer from a consumer in the streaming datapath.
// PARAMETERS
// DATA_WIDTH    8   payload width in bits
// BUFFER_DEPTH  10  FIFO entries; any value >= 2, not required to be a power of two
// SYNC_STAGES   2   synchronizer flops on in_req and out_ack; any value >= 2
// PORTS
// clk       in   1           single clock; all logic is rising-edge triggered
// rst_n     in   1           asynchronous active-low reset
// in_data   in   DATA_WIDTH  producer payload; sender keeps it stable from in_req rise until in_ack rise
// in_req    in   1           producer request (4-phase)
// in_ack    out  1           acknowledge to producer
// out_data  out  DATA_WIDTH  payload to consumer; stable while out_req=1
// out_req   out  1           request to consumer (4-phase)
// out_ack   in   1           consumer acknowledge
// BEHAVIOUR
// - Reset (rst_n=0, asynchronous): in_ack=0, out_req=0, out_data=0.
//   FIFO is empty, pointers and count are 0, both FSMs go to idle, sync chains are 0.
// - Synchronizers: in_req_s/out_ack_s = inputs delayed SYNC_STAGES clk cycles. FSMs use only *_s.
// - Input FSM, IN_IDLE -> IN_ACK:
//   if in_req_s=1 and FIFO not full: write in_data to FIFO, set in_ack<=1, go to IN_ACK.
// - Input FSM while full: stay in IN_IDLE with in_ack=0.
//   Backpressure lasts until a slot frees; the word is never dropped.
// - Input FSM, IN_ACK: when in_req_s=0, set in_ack<=0 and go to IN_IDLE.
//   The next word is accepted only after the full req-low/ack-low cycle.
// - Output FSM, OUT_IDLE: if FIFO not empty, set out_data<=head, out_req<=1, go to OUT_REQ.
// - Output FSM, OUT_REQ: when out_ack_s=1, set out_req<=0, pop head, go to OUT_WAIT.
// - Output FSM, OUT_WAIT: when out_ack_s=0, go to OUT_IDLE.
// - Simultaneous write and pop in one cycle: count is unchanged, both pointers advance.
//   A write into a full FIFO is never performed.
// - Pointers wrap from BUFFER_DEPTH-1 to 0.
//   Count width is $clog2(BUFFER_DEPTH+1) and ranges 0..BUFFER_DEPTH.
// - Ordering: strict FIFO. Every accepted word is delivered exactly once, unmodified.
// - Latency, in_req rise to in_ack rise: SYNC_STAGES+1 cycles when not full.
// - Latency, empty FIFO write to out_req rise: 1 cycle after the write edge.
// - out_data changes only on the OUT_IDLE->OUT_REQ transition.
// - Reset mid-transfer aborts both handshakes and discards FIFO contents. No partial state survives.
// TESTING
// - Reset: hold rst_n=0, toggle inputs -> in_ack=0, out_req=0, out_data=0 throughout.
// - Single word: send 0x01 with 4-phase handshake -> in_ack after 3 cycles.
//   out_req then presents out_data=0x01; ack it -> out_req drops.
// - Stream: send 0x01..0x20 while the consumer acks each word for 1 cycle -> received in order, zero errors.
// - Full: hold out_ack=0 and send 11 words -> first 10 acked, 11th waits with in_ack=0.
//   Then ack one output -> 11th word accepted.
// - Wrap and simultaneous: interleave 25 writes/pops with same-cycle push/pop -> order kept, no loss or dup.
// - Mid-reset: assert rst_n low with 5 words buffered -> outputs clear.
//   After release, the next sent word 0xA5 is the first delivered.

Source files
------------

// File: rtl/cdc_sync_handshake.sv
// cdc_sync_handshake
//   Single-clock 4-phase req/ack buffer between a producer and a consumer.
//   The in_req and out_ack inputs are treated as asynchronous. Each one passes
//   through a SYNC_STAGES-flop synchronizer. Accepted words are held in a
//   BUFFER_DEPTH-entry FIFO and re-issued on the output handshake in order.
//
// Ports
//   clk       in   1           rising-edge clock
//   rst_n     in   1           asynchronous active-low reset
//   in_data   in   DATA_WIDTH  producer payload, stable from in_req rise to in_ack rise
//   in_req    in   1           producer request (4-phase)
//   in_ack    out  1           acknowledge to producer
//   out_data  out  DATA_WIDTH  payload to consumer, stable while out_req=1
//   out_req   out  1           request to consumer (4-phase)
//   out_ack   in   1           consumer acknowledge
//
// state    | meaning
// IN_IDLE  | waiting for in_req_s=1 with a free FIFO slot
// IN_ACK   | word captured, in_ack=1, waiting for in_req_s=0
// OUT_IDLE | waiting for the FIFO to hold a word
// OUT_REQ  | head presented, out_req=1, waiting for out_ack_s=1
// OUT_WAIT | head popped, out_req=0, waiting for out_ack_s=0

module cdc_sync_handshake #(
  parameter int DATA_WIDTH   = 8,
  parameter int BUFFER_DEPTH = 10,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_req,
  output logic                  in_ack,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_req,
  input  logic                  out_ack
);

  localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUFFER_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUFFER_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUFFER_DEPTH);

  typedef enum logic {IN_IDLE, IN_ACK} in_state_e;
  typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_WAIT} out_state_e;

  logic [SYNC_STAGES-1:0] in_req_sync_q;
  logic [SYNC_STAGES-1:0] out_ack_sync_q;
  logic                   in_req_s;
  logic                   out_ack_s;

  logic [DATA_WIDTH-1:0]  mem_q [BUFFER_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   wr_en, rd_en;
  logic                   full, empty;

  in_state_e              in_state_q, in_state_d;
  out_state_e             out_state_q, out_state_d;
  logic                   in_ack_q, in_ack_d;
  logic                   out_req_q, out_req_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;

  // Synchronizers: the FSMs see only the last flop of each chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_req_sync_q  <= '0;
      out_ack_sync_q <= '0;
    end else begin
      in_req_sync_q  <= {in_req_sync_q[SYNC_STAGES-2:0], in_req};
      out_ack_sync_q <= {out_ack_sync_q[SYNC_STAGES-2:0], out_ack};
    end
  end

  assign in_req_s  = in_req_sync_q[SYNC_STAGES-1];
  assign out_ack_s = out_ack_sync_q[SYNC_STAGES-1];

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);

  // Input FSM: a write happens only from IN_IDLE with a free slot, so a full
  // FIFO holds the producer off until the consumer pops.
  always_comb begin
    in_state_d = in_state_q;
    in_ack_d   = in_ack_q;
    wr_en      = 1'b0;
    case (in_state_q)
      IN_IDLE: begin
        if (in_req_s && !full) begin
          wr_en      = 1'b1;
          in_ack_d   = 1'b1;
          in_state_d = IN_ACK;
        end
      end
      IN_ACK: begin
        if (!in_req_s) begin
          in_ack_d   = 1'b0;
          in_state_d = IN_IDLE;
        end
      end
      default: begin
        in_ack_d   = 1'b0;
        in_state_d = IN_IDLE;
      end
    endcase
  end

  // Output FSM: the head stays in the FIFO while presented. It is popped
  // only when the consumer acknowledges it.
  always_comb begin
    out_state_d = out_state_q;
    out_req_d   = out_req_q;
    out_data_d  = out_data_q;
    rd_en       = 1'b0;
    case (out_state_q)
      OUT_IDLE: begin
        if (!empty) begin
          out_data_d  = mem_q[rd_ptr_q];
          out_req_d   = 1'b1;
          out_state_d = OUT_REQ;
        end
      end
      OUT_REQ: begin
        if (out_ack_s) begin
          out_req_d   = 1'b0;
          rd_en       = 1'b1;
          out_state_d = OUT_WAIT;
        end
      end
      OUT_WAIT: begin
        if (!out_ack_s) out_state_d = OUT_IDLE;
      end
      default: begin
        out_req_d   = 1'b0;
        out_state_d = OUT_IDLE;
      end
    endcase
  end

  // Pointer and count update. The depth need not be a power of two, so the
  // pointers wrap explicitly.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    if (rd_en) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q  <= IN_IDLE;
      out_state_q <= OUT_IDLE;
      in_ack_q    <= 1'b0;
      out_req_q   <= 1'b0;
      out_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      in_ack_q    <= in_ack_d;
      out_req_q   <= out_req_d;
      out_data_q  <= out_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset. The pointers and count define which entries hold data.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

  assign in_ack   = in_ack_q;
  assign out_req  = out_req_q;
  assign out_data = out_data_q;

endmodule

// File: tb/tb_cdc_sync_handshake.sv
module tb_cdc_sync_handshake;

  localparam int DW = 8;
  localparam int TO = 300;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_req;
  logic          in_ack;
  logic [DW-1:0] out_data;
  logic          out_req;
  logic          out_ack;

  int n_checks = 0;
  int n_fail   = 0;

  // Words the DUT has acknowledged and not yet delivered, oldest first.
  logic [DW-1:0] exp_q[$];

  cdc_sync_handshake #(.DATA_WIDTH(DW), .BUFFER_DEPTH(10), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_req   (in_req),
    .in_ack   (in_ack),
    .out_data (out_data),
    .out_req  (out_req),
    .out_ack  (out_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // mode 0: words are base+i; mode 1: random words.
  task automatic produce(input int n, input int mode, input logic [DW-1:0] base,
                         input int max_gap);
    logic [DW-1:0] d;
    int cyc;
    for (int i = 0; i < n; i++) begin
      d = (mode == 0) ? base + DW'(i) : DW'($urandom);
      @(negedge clk);
      in_data = d;
      in_req  = 1'b1;
      cyc = 0;
      while (!in_ack && cyc < TO) begin @(negedge clk); cyc++; end
      check("in_ack_rise", {31'd0, in_ack}, 32'd1);
      exp_q.push_back(d);
      in_req = 1'b0;
      cyc = 0;
      while (in_ack && cyc < TO) begin @(negedge clk); cyc++; end
      check("in_ack_fall", {31'd0, in_ack}, 32'd0);
      repeat ($urandom_range(max_gap, 0)) @(negedge clk);
    end
  endtask

  task automatic consume(input int n, input int max_gap);
    logic [DW-1:0] e;
    int cyc;
    for (int i = 0; i < n; i++) begin
      cyc = 0;
      while (!out_req && cyc < TO) begin @(negedge clk); cyc++; end
      check("out_req_rise", {31'd0, out_req}, 32'd1);
      if (exp_q.size() == 0) begin
        check("model_nonempty", 32'd0, 32'd1);
        e = 'x;
      end else begin
        e = exp_q.pop_front();
      end
      check("out_data", {24'd0, out_data}, {24'd0, e});
      repeat ($urandom_range(max_gap, 0)) begin
        @(negedge clk);
        check("out_data_stable", {24'd0, out_data}, {24'd0, e});
      end
      out_ack = 1'b1;
      cyc = 0;
      while (out_req && cyc < TO) begin @(negedge clk); cyc++; end
      check("out_req_fall", {31'd0, out_req}, 32'd0);
      out_ack = 1'b0;
    end
  endtask

  initial begin
    int cyc;
    int saw_ack;

    // Reset with toggling inputs.
    rst_n = 1'b0; in_req = 1'b0; out_ack = 1'b0; in_data = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_req  = 1'($urandom);
      out_ack = 1'($urandom);
      in_data = DW'($urandom);
      #1;
      check("rst_in_ack",   {31'd0, in_ack},   32'd0);
      check("rst_out_req",  {31'd0, out_req},  32'd0);
      check("rst_out_data", {24'd0, out_data}, 32'd0);
    end
    @(negedge clk);
    in_req = 1'b0; out_ack = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word: ack latency, out_req latency, then consumer handshake.
    in_data = 8'h01;
    in_req  = 1'b1;
    cyc = 0;
    while (!in_ack && cyc < TO) begin @(negedge clk); cyc++; end
    check("ack_latency", cyc, 3);
    check("out_req_before", {31'd0, out_req}, 32'd0);
    exp_q.push_back(8'h01);
    @(negedge clk);
    check("out_req_latency", {31'd0, out_req}, 32'd1);
    check("single_out_data", {24'd0, out_data}, 32'h01);
    in_req = 1'b0;
    cyc = 0;
    while (in_ack && cyc < TO) begin @(negedge clk); cyc++; end
    check("single_ack_fall", {31'd0, in_ack}, 32'd0);
    consume(1, 2);

    // Stream 0x01..0x20 with a quick consumer.
    fork
      produce(32, 0, 8'h01, 1);
      consume(32, 0);
    join

    // Full FIFO backpressure.
    produce(10, 0, 8'h40, 0);
    @(negedge clk);
    in_data = 8'h4A;
    in_req  = 1'b1;
    saw_ack = 0;
    repeat (20) begin
      @(negedge clk);
      if (in_ack) saw_ack = 1;
    end
    check("full_backpressure", saw_ack, 0);
    consume(1, 0);
    cyc = 0;
    while (!in_ack && cyc < TO) begin @(negedge clk); cyc++; end
    check("eleventh_accepted", {31'd0, in_ack}, 32'd1);
    exp_q.push_back(8'h4A);
    in_req = 1'b0;
    cyc = 0;
    while (in_ack && cyc < TO) begin @(negedge clk); cyc++; end
    check("eleventh_ack_fall", {31'd0, in_ack}, 32'd0);
    consume(10, 1);
    check("drain_model_empty", exp_q.size(), 0);

    // Random words, random pacing on both sides: exercises wrap and
    // same-cycle push/pop.
    fork
      produce(25, 1, 8'h00, 2);
      consume(25, 3);
    join
    fork
      produce(40, 1, 8'h00, 4);
      consume(40, 1);
    join
    check("wrap_model_empty", exp_q.size(), 0);

    // Reset with 5 words buffered.
    produce(5, 1, 8'h00, 0);
    @(negedge clk);
    check("pre_reset_out_req", {31'd0, out_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ack",   {31'd0, in_ack},   32'd0);
    check("midrst_out_req",  {31'd0, out_req},  32'd0);
    check("midrst_out_data", {24'd0, out_data}, 32'd0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_out_req", {31'd0, out_req}, 32'd0);
    produce(1, 0, 8'hA5, 0);
    consume(1, 0);
    repeat (10) @(negedge clk);
    check("post_rst_no_extra", {31'd0, out_req}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
